// File: rtl/mul16_if.sv
// Command/result handshake bundle for the sequential 16x16 multiplier.
// The master issues commands and accepts products; the slave is the multiplier.
interface mul16_if;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        done_valid;
    logic        done_ready;
    logic [15:0] product;
    logic        busy;

    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, done_valid, product, busy
    );

    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, done_valid, product, busy
    );
endinterface

// File: rtl/mul16_seq.sv
// Multi-cycle shift-add multiplier: one 16-bit adder reused over up to 16 iterations,
// returning the low 16 bits of a*b through valid/ready handshakes.
module mul16_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    mul16_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] add_sum;
    logic        last_iter;

    // Shared adder; the carry out of bit 15 is dropped, giving a*b mod 2^16.
    assign add_sum   = acc_q + mcand_q;
    assign last_iter = (cnt_q == 4'd15) || (EARLY_EXIT && (mplier_q[15:1] == 15'd0));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = 16'd0;
                    cnt_d    = 4'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) acc_d = add_sum;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                cnt_d    = cnt_q + 4'd1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                if (bus.done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            acc_q    <= 16'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.busy        = (state_q == RUN) || (state_q == DONE);
    assign bus.product     = acc_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Drives a fixed-latency and an early-exit multiplier side by side and compares
// products and latencies against plain-arithmetic expectations.
module tb_mul16_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mul16_if if0 ();
    mul16_if if1 ();

    mul16_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mul16_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic f_dv(input int sel);
        return (sel != 0) ? if1.done_valid : if0.done_valid;
    endfunction
    function automatic logic f_sr(input int sel);
        return (sel != 0) ? if1.start_ready : if0.start_ready;
    endfunction
    function automatic logic f_busy(input int sel);
        return (sel != 0) ? if1.busy : if0.busy;
    endfunction
    function automatic logic [15:0] f_prod(input int sel);
        return (sel != 0) ? if1.product : if0.product;
    endfunction

    task automatic set_start(input int sel, input logic sv, input logic [15:0] a, input logic [15:0] b);
        if (sel != 0) begin
            if1.start_valid = sv; if1.a = a; if1.b = b;
        end else begin
            if0.start_valid = sv; if0.a = a; if0.b = b;
        end
    endtask

    task automatic set_dr(input int sel, input logic dr);
        if (sel != 0) if1.done_ready = dr;
        else          if0.done_ready = dr;
    endtask

    // Reference: low half of the true product, and cycle count by unit type.
    function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = 32'(a) * 32'(b);
        return full[15:0];
    endfunction

    function automatic int ref_lat(input int sel, input logic [15:0] b);
        int hb;
        if (sel == 0) return 17;
        hb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) hb = i;
        return (hb < 0) ? 2 : hb + 2;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that retires the result.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input int stall, input bit poke_dr);
        logic [15:0] exp;
        int          cyc;
        int          w;
        exp = ref_prod(a, b);
        w = 0;
        while (!f_sr(sel) && w < 40) begin
            @(posedge clk); #1; w++;
        end
        chk("start_ready", 32'(f_sr(sel)), 32'd1);
        set_start(sel, 1'b1, a, b);
        @(posedge clk); #1;
        set_start(sel, 1'b0, 16'h0, 16'h0);
        chk("busy_run", 32'(f_busy(sel)), 32'd1);
        chk("not_ready_run", 32'(f_sr(sel)), 32'd0);
        cyc = 0;
        while (!f_dv(sel) && cyc < 40) begin
            if (poke_dr) set_dr(sel, 1'($urandom_range(0, 1)));
            @(posedge clk); #1; cyc++;
        end
        set_dr(sel, 1'b0);
        chk("latency", 32'(cyc + 1), 32'(ref_lat(sel, b)));
        chk("product", 32'(f_prod(sel)), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            set_start(sel, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            chk("hold_valid", 32'(f_dv(sel)), 32'd1);
            chk("hold_prod", 32'(f_prod(sel)), 32'(exp));
        end
        set_start(sel, 1'b0, 16'h0, 16'h0);
        set_dr(sel, 1'b1);
        @(posedge clk); #1;
        set_dr(sel, 1'b0);
        chk("idle_ready", 32'(f_sr(sel)), 32'd1);
        chk("idle_no_valid", 32'(f_dv(sel)), 32'd0);
        chk("idle_keep_prod", 32'(f_prod(sel)), 32'(exp));
    endtask

    initial begin
        set_start(0, 1'b0, 16'h0, 16'h0);
        set_start(1, 1'b0, 16'h0, 16'h0);
        set_dr(0, 1'b0);
        set_dr(1, 1'b0);
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", 32'(f_sr(s)), 32'd1);
            chk("rst_valid", 32'(f_dv(s)), 32'd0);
            chk("rst_busy", 32'(f_busy(s)), 32'd0);
            chk("rst_prod", 32'(f_prod(s)), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products on the fixed-latency unit.
        run_op(0, 16'd3, 16'd5, 0, 1'b0);
        run_op(0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(0, 16'h0100, 16'h0100, 0, 1'b0);
        run_op(0, 16'hFFFD, 16'h0007, 0, 1'b0);
        run_op(0, 16'h0000, 16'h1234, 0, 1'b0);
        // Backpressure with start_valid noise while holding.
        run_op(0, 16'd3, 16'd5, 5, 1'b0);

        // Abort mid-run by reset.
        set_start(0, 1'b1, 16'd3, 16'd5);
        @(posedge clk); #1;
        set_start(0, 1'b0, 16'h0, 16'h0);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(f_sr(0)), 32'd1);
        chk("abort_prod", 32'(f_prod(0)), 32'd0);
        chk("abort_busy", 32'(f_busy(0)), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (f_dv(0)) seen++;
            end
            chk("abort_no_valid", 32'(seen), 32'd0);
        end
        run_op(0, 16'd2, 16'd9, 0, 1'b0);

        // Early-exit unit.
        run_op(1, 16'd7, 16'd3, 0, 1'b0);
        run_op(1, 16'h1234, 16'd0, 0, 1'b0);
        run_op(1, 16'd1, 16'h8000, 0, 1'b0);
        run_op(1, 16'hFFFD, 16'h0007, 2, 1'b0);

        // Random back-to-back traffic with done_ready noise during RUN.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            run_op(i % 2, ra, rb, $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
